// File: rtl/debug_capture.sv
// Snoops CPU bus cycles into a 16-byte debug scratch window and drains the bytes to a host.
// Optional macro DEBUG_CAPTURE_READS_EN also captures reads to the window.
module debug_capture #(
  parameter logic [15:0] BASE_ADDR = 16'h7FF0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        ADS_n,
  input  logic        WDS_n,
  input  logic        RDS_n,
  input  logic        BAEN_n,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  data,
  input  logic        out_ready,
  input  logic        ovr_clr,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        overrun,
  output logic        busy
);

  // Output handshake: a byte moves when out_valid & out_ready on a rising
  // edge; out_data/out_idx/out_last hold steady while out_valid & !out_ready.
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, WAIT} state_t;

  state_t      state;
  logic [15:0] mask;
  logic [7:0]  mem [16];
  logic        hit;
  logic [3:0]  off;
  logic        wds_q;
  logic        rd_first;
  logic        store;
  logic [15:0] mask_w;
  logic [15:0] rest;
  logic [3:0]  next_idx;
  logic        fire;

`ifdef DEBUG_CAPTURE_READS_EN
  logic rds_q;
  always_ff @(posedge clk or posedge RST) begin
    if (RST) rds_q <= 1'b1;
    else     rds_q <= RDS_n;
  end
  assign rd_first = !RDS_n && rds_q;
`else
  logic unused_rds;
  assign unused_rds = RDS_n;
  assign rd_first   = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign fire = out_valid && out_ready;

  always_comb begin
    store  = (state == CAPTURE) && hit && ((!WDS_n && wds_q) || rd_first);
    mask_w = mask;
    if (store) mask_w[off] = 1'b1;
    // Lowest pending offset goes out next.
    next_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) next_idx = i[3:0];
    end
    rest = mask;
    rest[next_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (store) mem[off] <= data;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      mask      <= 16'd0;
      hit       <= 1'b0;
      off       <= 4'd0;
      wds_q     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_idx   <= 4'd0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wds_q <= WDS_n;
      if (!ADS_n) begin
        hit <= (mem_addr[15:4] == BASE_ADDR[15:4]);
        off <= mem_addr[3:0];
      end
      if (state == DRAIN && BAEN_n) overrun <= 1'b1;
      else if (ovr_clr)             overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (BAEN_n) begin
            state <= CAPTURE;
            mask  <= 16'd0;
          end
        end
        CAPTURE: begin
          mask <= mask_w;
          if (!BAEN_n) state <= (mask_w != 16'd0) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (fire && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= BAEN_n ? WAIT : IDLE;
          end else if (!out_valid || fire) begin
            out_valid <= 1'b1;
            out_data  <= mem[next_idx];
            out_idx   <= next_idx;
            out_last  <= (rest == 16'd0);
            mask      <= rest;
          end
        end
        WAIT: begin
          if (!BAEN_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_capture.sv
// Randomized bench for debug_capture: a window model predicts each drain into a queue
// that a negedge monitor checks against every accepted output byte.
module tb_debug_capture;

  localparam logic [15:0] BASE = 16'h7FF0;

  logic        clk = 1'b0;
  logic        RST;
  logic        ADS_n, WDS_n, RDS_n, BAEN_n;
  logic [15:0] mem_addr;
  logic [7:0]  data;
  logic        out_ready, ovr_clr;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_last, overrun, busy;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  logic [7:0]  m_mem [16];
  logic [15:0] m_mask;
  bit          m_cap = 0;
  bit          rnd_ready = 0;

  debug_capture #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .RST(RST), .ADS_n(ADS_n), .WDS_n(WDS_n), .RDS_n(RDS_n),
    .BAEN_n(BAEN_n), .mem_addr(mem_addr), .data(data), .out_ready(out_ready),
    .ovr_clr(ovr_clr), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the capture window.
  function automatic void model_store(input logic [15:0] addr, input logic [7:0] d);
    if (m_cap && addr[15:4] == BASE[15:4]) begin
      m_mem[addr[3:0]]  = d;
      m_mask[addr[3:0]] = 1'b1;
    end
  endfunction

  task automatic begin_session();
    BAEN_n = 1'b1;
    @(posedge clk); #1;
    m_cap  = 1;
    m_mask = 16'd0;
  endtask

  task automatic end_session();
    BAEN_n = 1'b0;
    m_cap  = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_mask[i]) exp_q.push_back({((m_mask >> (i + 1)) == 16'd0), 4'(i), m_mem[i]});
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
    int hold;
    hold = $urandom_range(1, 3);
    ADS_n = 1'b0; mem_addr = addr;
    @(posedge clk); #1;
    ADS_n = 1'b1; WDS_n = 1'b0; data = d;
    model_store(addr, d);
    @(posedge clk); #1;
    data = ~d;
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    WDS_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [7:0] d);
    int hold;
    hold = $urandom_range(1, 3);
    ADS_n = 1'b0; mem_addr = addr;
    @(posedge clk); #1;
    ADS_n = 1'b1; RDS_n = 1'b0; data = d;
`ifdef DEBUG_CAPTURE_READS_EN
    model_store(addr, d);
`endif
    @(posedge clk); #1;
    data = ~d;
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    RDS_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
    if (!done) exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Random out_ready when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks every accepted byte and output stability while stalled.
  initial begin
    bit stalled;
    logic [13:0] prev;
    stalled = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (RST) begin
        stalled = 0;
      end else begin
        if (stalled) chk("stall_stable", {18'd0, out_valid, out_last, out_idx, out_data}, {18'd0, prev});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got idx %0d data %0h, nothing expected at %0t",
                     out_idx, out_data, $time);
          end else begin
            chk("out_byte", {19'd0, out_last, out_idx, out_data}, {19'd0, exp_q.pop_front()});
          end
        end
        stalled = out_valid && !out_ready;
        prev    = {out_valid, out_last, out_idx, out_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    RST = 1'b1; ADS_n = 1'b1; WDS_n = 1'b1; RDS_n = 1'b1; BAEN_n = 1'b0;
    mem_addr = 16'd0; data = 8'd0; out_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_idx",   {28'd0, out_idx},   32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_overrun",   {31'd0, overrun},   32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    RST = 1'b0;
    @(posedge clk); #1;

    // Two bytes out of order, stalled host, then single transfer.
    out_ready = 1'b0;
    begin_session();
    bus_write(16'h7FF3, 8'h12);
    bus_write(16'h7FF0, 8'hA5);
    end_session();
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    n0 = exp_q.size();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("one_xfer", exp_q.size(), n0 - 1);
    chk("second_idx", {28'd0, out_idx}, 32'd3);
    @(posedge clk); #1;
    rnd_ready = 1;
    wait_drain(100);
    chk("idle_after_drain", {31'd0, busy}, 32'd0);

    // Overrun: session re-raised mid-drain.
    rnd_ready = 0; out_ready = 1'b0;
    begin_session();
    bus_write(16'h7FF1, 8'h01);
    bus_write(16'h7FF6, 8'h06);
    bus_write(16'h7FFA, 8'h0A);
    end_session();
    BAEN_n = 1'b1;
    bus_write(16'h7FF5, 8'h55);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("set_beats_clr", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1;
    rnd_ready = 1;
    wait_drain(100);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    bus_write(16'h7FF7, 8'h77);
    BAEN_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wait_to_idle", {31'd0, busy}, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;

    // Only misses: no drain at all.
    begin_session();
    bus_write(16'h7FE0, 8'hE0);
    bus_write(16'h8FF1, 8'hF1);
    end_session();
    wait_drain(50);
    chk("nohit_busy", {31'd0, busy}, 32'd0);
    chk("nohit_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a drain.
    rnd_ready = 0; out_ready = 1'b0;
    begin_session();
    bus_write(16'h7FF1, 8'h11);
    bus_write(16'h7FF4, 8'h22);
    bus_write(16'h7FF9, 8'h33);
    end_session();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, out_data},  32'd0);
    chk("mid_rst_idx",   {28'd0, out_idx},   32'd0);
    chk("mid_rst_last",  {31'd0, out_last},  32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    RST = 1'b0;
    @(posedge clk); #1;
    rnd_ready = 1;
    begin_session();
    bus_write(16'h7FFF, 8'h3C);
    end_session();
    wait_drain(50);

    // Read capture (only with reads enabled).
    begin_session();
    bus_read(16'h7FF2, 8'h77);
    bus_write(16'h7FF8, 8'h5A);
    end_session();
    wait_drain(100);

    // Randomized sessions.
    for (int s = 0; s < 20; s++) begin
      int n;
      n = $urandom_range(0, 6);
      begin_session();
      for (int k = 0; k < n; k++) begin
        logic [15:0] a;
        logic [7:0]  d;
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) a = 16'($urandom);
        else a = {BASE[15:4], ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15))};
        if ($urandom_range(0, 4) == 0) bus_read(a, d);
        else bus_write(a, d);
      end
      end_session();
      wait_drain(200);
      chk("rand_idle", {31'd0, busy}, 32'd0);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
